note_div_scheduler: RTL and testbench

- Replaces the two combinational 100 MHz / frequency dividers feeding note_gen with one shared, sequential restoring divider.
- The divider is time-multiplexed between the left and right channels on a fixed round-robin schedule.
- Applies the octave shift and the silence rule, then commits both note divisors together so that note_gen never sees a left/right pair from different snapshots.
- Sits between music_example / volume_octave_controller and note_gen.

---
 rtl/note_div_scheduler_pkg.sv | 45 ++++
 rtl/note_div_scheduler_if.sv | 24 ++
 rtl/note_div_scheduler_divider.sv | 73 +++++++
 rtl/note_div_scheduler.sv | 140 ++++++++++++++
 tb/tb_note_div_scheduler.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/note_div_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the note divisor scheduler.
package note_div_scheduler_pkg;

    localparam int unsigned CLK_HZ  = 100_000_000;
    localparam int unsigned SILENCE = CLK_HZ;
    localparam int unsigned NUM_W   = 27;
    localparam int unsigned OUT_W   = 22;

    localparam logic [2:0] OCT_DOWN = 3'd1;
    localparam logic [2:0] OCT_UP   = 3'd3;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        DIV_L  = 2'd1,
        DIV_R  = 2'd2,
        COMMIT = 2'd3
    } sched_state_t;

    // Octave-shifted divisor, widened by one bit so that shifting up never truncates.
    function automatic logic [32:0] effDivisor(input logic [31:0] f, input logic [2:0] oct);
        logic [32:0] d;
        if (oct == OCT_DOWN) begin
            d = {1'b0, f >> 1};
        end else if (oct == OCT_UP) begin
            d = {f, 1'b0};
        end else begin
            d = {1'b0, f};
        end
        return d;
    endfunction

    // Silence forces a divisor of 1; quotients too large for note_gen saturate.
    function automatic logic [OUT_W-1:0] applyRules(input logic silent, input logic [NUM_W-1:0] q);
        logic [OUT_W-1:0] r;
        if (silent) begin
            r = OUT_W'(1);
        end else if (|q[NUM_W-1:OUT_W]) begin
            r = '1;
        end else begin
            r = q[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/note_div_scheduler_if.sv
// Bundle between the frequency/octave sources and note_gen.
interface note_div_scheduler_if;
    import note_div_scheduler_pkg::*;

    logic [31:0]      freq_l;
    logic [31:0]      freq_r;
    logic [2:0]       octave;
    logic [OUT_W-1:0] note_div_l;
    logic [OUT_W-1:0] note_div_r;
    logic             div_valid;
    logic             update;
    logic             busy;

    modport master (
        output freq_l, freq_r, octave,
        input  note_div_l, note_div_r, div_valid, update, busy
    );

    modport slave (
        input  freq_l, freq_r, octave,
        output note_div_l, note_div_r, div_valid, update, busy
    );

endinterface

// File: rtl/note_div_scheduler_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// A start pulse performs the first iteration on the fresh operands, so all
// NUM_W iterations fit in NUM_W cycles; done is high in the following cycle.
module seq_restoring_divider
    import note_div_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [NUM_W-1:0] i_dividend,
    input  logic [32:0]      i_divisor,
    output logic             o_done,
    output logic [NUM_W-1:0] o_quotient
);

    localparam logic [4:0] CNT_LAST = 5'(NUM_W - 1);

    logic [33:0]      r_rem;
    logic [NUM_W-1:0] r_quo;
    logic [4:0]       r_cnt;
    logic             r_run;
    logic             r_done;

    logic [33:0]      w_remIn;
    logic [NUM_W-1:0] w_quoIn;
    logic [34:0]      w_remShift;
    logic [34:0]      w_divExt;
    logic             w_fits;
    logic [33:0]      w_remNext;
    logic [NUM_W-1:0] w_quoNext;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_remIn    = i_start ? '0 : r_rem;
        w_quoIn    = i_start ? i_dividend : r_quo;
        w_remShift = {w_remIn, w_quoIn[NUM_W-1]};
        w_divExt   = {2'b00, i_divisor};
        w_fits     = (w_remShift >= w_divExt);
        w_remNext  = w_fits ? 34'(w_remShift - w_divExt) : w_remShift[33:0];
        w_quoNext  = {w_quoIn[NUM_W-2:0], w_fits};
    end

    // Iteration registers and the fixed-length iteration count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start || r_run) begin
                r_rem <= w_remNext;
                r_quo <= w_quoNext;
                if (i_start) begin
                    r_cnt <= 5'd1;
                    r_run <= 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt  <= '0;
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 5'd1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/note_div_scheduler.sv
// Round-robin scheduler sharing one divider between the left and right channels.
// Each 56-cycle round snapshots the inputs, divides left then right, and
// commits both note divisors on the same edge.
module note_div_scheduler
    import note_div_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    note_div_scheduler_if.slave bus
);

    localparam logic [4:0] ITER_LAST = 5'(NUM_W - 1);

    sched_state_t     r_state;
    sched_state_t     w_stateNext;
    logic [4:0]       r_iter;

    logic [31:0]      r_snapFreqL;
    logic [31:0]      r_snapFreqR;
    logic [2:0]       r_snapOct;
    logic [OUT_W-1:0] r_stageL;
    logic [OUT_W-1:0] r_noteDivL;
    logic [OUT_W-1:0] r_noteDivR;
    logic             r_divValid;

    logic [32:0]      w_divL;
    logic [32:0]      w_divR;
    logic             w_silentL;
    logic             w_silentR;
    logic [32:0]      w_divisor;
    logic             w_start;
    logic             w_done;
    logic [NUM_W-1:0] w_quotient;
    logic             w_update;
    logic             w_busy;

    assign w_divL    = effDivisor(r_snapFreqL, r_snapOct);
    assign w_divR    = effDivisor(r_snapFreqR, r_snapOct);
    assign w_silentL = (r_snapFreqL == 32'(SILENCE)) || (w_divL == '0);
    assign w_silentR = (r_snapFreqR == 32'(SILENCE)) || (w_divR == '0);
    assign w_divisor = (r_state == DIV_R) ? w_divR : w_divL;
    assign w_start   = ((r_state == DIV_L) || (r_state == DIV_R)) && (r_iter == '0);

    seq_restoring_divider u_divider (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (NUM_W'(CLK_HZ)),
        .i_divisor  (w_divisor),
        .o_done     (w_done),
        .o_quotient (w_quotient)
    );

    // State register plus the cycle counter that times each division phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SAMPLE;
            r_iter  <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state != w_stateNext) begin
                r_iter <= '0;
            end else begin
                r_iter <= r_iter + 5'd1;
            end
        end
    end

    // Fixed schedule with no early exit, plus the state-decoded status outputs.
    always_comb begin
        w_stateNext = r_state;
        w_update    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            SAMPLE: begin
                w_busy      = 1'b0;
                w_stateNext = DIV_L;
            end
            DIV_L: begin
                if (r_iter == ITER_LAST) begin
                    w_stateNext = DIV_R;
                end
            end
            DIV_R: begin
                if (r_iter == ITER_LAST) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                w_update    = 1'b1;
                w_stateNext = SAMPLE;
            end
            default: begin
                w_stateNext = SAMPLE;
            end
        endcase
    end

    // Input snapshot so both channels of a round use the same frequencies and octave.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snapFreqL <= '0;
            r_snapFreqR <= '0;
            r_snapOct   <= '0;
        end else if (r_state == SAMPLE) begin
            r_snapFreqL <= bus.freq_l;
            r_snapFreqR <= bus.freq_r;
            r_snapOct   <= bus.octave;
        end
    end

    // Hold the finished left result while the divider works on the right channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stageL <= '0;
        end else if ((r_state == DIV_R) && w_done) begin
            r_stageL <= applyRules(w_silentL, w_quotient);
        end
    end

    // Commit both channels together; reset takes priority over a pending commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_noteDivL <= OUT_W'(1);
            r_noteDivR <= OUT_W'(1);
            r_divValid <= 1'b0;
        end else if (r_state == COMMIT) begin
            r_noteDivL <= r_stageL;
            r_noteDivR <= applyRules(w_silentR, w_quotient);
            r_divValid <= 1'b1;
        end
    end

    assign bus.note_div_l = r_noteDivL;
    assign bus.note_div_r = r_noteDivR;
    assign bus.div_valid  = r_divValid;
    assign bus.update     = w_update;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_note_div_scheduler.sv
// Directed bench for note_div_scheduler with hand-computed divisors.
module tb_note_div_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [21:0] prevL;
    logic [21:0] prevR;
    logic        prevUpdate;
    logic        edgeRst;
    logic        monOn;

    note_div_scheduler_if bus ();

    note_div_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Remember whether reset was applied at the most recent active edge.
    always @(posedge clk) begin
        edgeRst <= rst;
    end

    // Outputs may only move on the edge closing an update cycle or on a reset edge.
    always @(negedge clk) begin
        if (monOn && !edgeRst && !prevUpdate) begin
            total++;
            assert (bus.note_div_l === prevL && bus.note_div_r === prevR)
            else begin
                bad++;
                $error("[TB] FAIL stable observed=%0d/%0d expected=%0d/%0d",
                       bus.note_div_l, bus.note_div_r, prevL, prevR);
            end
        end
        prevL      = bus.note_div_l;
        prevR      = bus.note_div_r;
        prevUpdate = bus.update;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fl, input logic [31:0] fr, input logic [2:0] oct);
        bus.freq_l = fl;
        bus.freq_r = fr;
        bus.octave = oct;
    endtask

    // Called from a SAMPLE cycle; waits for the update pulse, then checks the commit.
    task automatic runRound(input string tag, input int expCycles, input logic expValidAtUpdate,
                            input logic [31:0] expL, input logic [31:0] expR);
        int n;
        n = 0;
        while (bus.update !== 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'(expCycles));
        checkOutput({tag, " busy@update"}, 32'(bus.busy), 32'd1);
        checkOutput({tag, " valid@update"}, 32'(bus.div_valid), 32'(expValidAtUpdate));
        @(negedge clk);
        checkOutput({tag, " left"}, 32'(bus.note_div_l), expL);
        checkOutput({tag, " right"}, 32'(bus.note_div_r), expR);
        checkOutput({tag, " valid"}, 32'(bus.div_valid), 32'd1);
        checkOutput({tag, " update low"}, 32'(bus.update), 32'd0);
        checkOutput({tag, " busy low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        monOn      = 1'b0;
        prevUpdate = 1'b0;
        prevL      = '0;
        prevR      = '0;
        rst        = 1'b1;
        applyStimulus(32'd440, 32'd440, 3'd2);

        repeat (3) @(negedge clk);
        checkOutput("reset left", 32'(bus.note_div_l), 32'd1);
        checkOutput("reset right", 32'(bus.note_div_r), 32'd1);
        checkOutput("reset valid", 32'(bus.div_valid), 32'd0);
        checkOutput("reset update", 32'(bus.update), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        monOn = 1'b1;
        rst   = 1'b0;

        // First commit lands in cycle 56 after reset release.
        runRound("first", 55, 1'b0, 32'd227272, 32'd227272);

        applyStimulus(32'd440, 32'd262, 3'd1);
        runRound("oct down", 55, 1'b1, 32'd454545, 32'd763358);

        applyStimulus(32'd440, 32'd262, 3'd3);
        runRound("oct up", 55, 1'b1, 32'd113636, 32'd190839);

        applyStimulus(32'd100_000_000, 32'd0, 3'd2);
        runRound("silence", 55, 1'b1, 32'd1, 32'd1);

        applyStimulus(32'd10, 32'd440, 3'd2);
        runRound("sat plain", 55, 1'b1, 32'h3FFFFF, 32'd227272);

        applyStimulus(32'd47, 32'd440, 3'd1);
        runRound("sat down", 55, 1'b1, 32'h3FFFFF, 32'd454545);

        // Change freq_r in the middle of DIV_L; it must wait for the next round.
        applyStimulus(32'd440, 32'd440, 3'd2);
        repeat (5) @(negedge clk);
        bus.freq_r = 32'd880;
        runRound("late change", 50, 1'b1, 32'd227272, 32'd227272);
        runRound("next round", 55, 1'b1, 32'd227272, 32'd113636);

        // One-cycle reset in the middle of DIV_R aborts the round.
        repeat (35) @(negedge clk);
        checkOutput("busy in div_r", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort left", 32'(bus.note_div_l), 32'd1);
        checkOutput("abort right", 32'(bus.note_div_r), 32'd1);
        checkOutput("abort valid", 32'(bus.div_valid), 32'd0);
        checkOutput("abort update", 32'(bus.update), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        runRound("post reset", 55, 1'b0, 32'd227272, 32'd113636);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
